// File: rtl/simple_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simple_uart_pkg: shared state encodings and UART frame constants.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package simple_uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_WRITE     = 2'd1,
    ARB_WAIT_DONE = 2'd2,
    ARB_GAP       = 2'd3
  } arb_state_e;

  // 8N1: start bit + 8 data bits + stop bit
  localparam int unsigned UART_FRAME_BITS = 10;

  localparam int unsigned GAP_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/simple_uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: combinational rotating-priority picker; search starts    |
// | at ptr_i+1 and wraps. Revision: 1.0                                  |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        idx_o                    = cand[IDX_W-1:0];
        gnt_o[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/simple_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simple_uart_tx_arbiter: round-robin sharing of one 8N1 UART TX among |
// | NUM_REQ byte requesters. Optional message lock: define               |
// | SIMPLE_UART_TX_ARB_LOCK_EN. Revision: 1.0                            |
// +----------------------------------------------------------------------+
module simple_uart_tx_arbiter
  import simple_uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       clock,
  input  logic                       srst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_value,
  output logic                       tx_value_write,
  input  logic                       tx_value_done,
  output logic                       busy,
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       locked,
`endif
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [7:0]           txv_q, txv_d;
  logic                 busy_q, busy_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic [NUM_REQ-1:0]   cand_req;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 accept;

`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;

  // While locked only the owner (last accepted requester) may be picked
  assign cand_req = lock_q ? (req_valid & (NUM_REQ'(1) << grant_q)) : req_valid;
  assign locked   = lock_q;
`else
  assign cand_req = req_valid;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (cand_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign accept         = srst_n && (state_q == ARB_IDLE) && arb_any;
  assign req_ready      = accept ? arb_gnt : '0;
  assign tx_value       = txv_q;
  assign tx_value_write = (state_q == ARB_WRITE);
  assign busy           = busy_q;
  assign grant_id       = grant_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    txv_d   = txv_q;
    busy_d  = busy_q;
    gap_d   = gap_q;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          txv_d   = req_data[{arb_idx, 3'b000} +: 8];
          grant_d = arb_idx;
          ptr_d   = arb_idx;
          busy_d  = 1'b1;
          state_d = ARB_WRITE;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
          lock_d  = ~req_last[arb_idx];
`endif
        end
      end
      ARB_WRITE: begin
        state_d = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (tx_value_done) begin
          busy_d  = 1'b0;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
        end
      end
      ARB_GAP: begin
        gap_d = gap_q + GAP_CNT_W'(1);
        if (gap_q == GAP_LAST) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      txv_q   <= 8'h00;
      busy_q  <= 1'b0;
      gap_q   <= '0;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      txv_q   <= txv_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simple_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_simple_uart_tx_arbiter: randomized bench with a transaction-level |
// | round-robin model. Revision: 1.0                                     |
// +----------------------------------------------------------------------+
module tb_simple_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int GAP_B = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           srst_n;
  logic [N-1:0]   valid_a, ready_a, valid_b, ready_b;
  logic [8*N-1:0] data_a, data_b;
  logic [7:0]     txv_a, txv_b;
  logic           txw_a, txw_b, done_a, done_b, busy_a, busy_b;
  logic [1:0]     gid_a, gid_b;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  logic [N-1:0]   last_a;
  logic           locked_a, locked_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr;  // model: index of the most recently served requester

  simple_uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0)) dut_a (
    .clock(clock), .srst_n(srst_n), .req_valid(valid_a), .req_data(data_a),
    .req_ready(ready_a), .tx_value(txv_a), .tx_value_write(txw_a),
    .tx_value_done(done_a), .busy(busy_a),
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    .req_last(last_a), .locked(locked_a),
`endif
    .grant_id(gid_a)
  );

  simple_uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP_B)) dut_b (
    .clock(clock), .srst_n(srst_n), .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .tx_value(txv_b), .tx_value_write(txw_b),
    .tx_value_done(done_b), .busy(busy_b),
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    .req_last({N{1'b1}}), .locked(locked_b),
`endif
    .grant_id(gid_b)
  );

  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    srst_n = 1'b0; valid_a = '0; valid_b = '0; done_a = 1'b0; done_b = 1'b0;
    tick(); tick();
    srst_n = 1'b1;
    m_ptr  = N - 1;
  endtask

  // One full transfer on dut_a: accept, write, `hold` busy cycles with noise on req_valid, done.
  task automatic serve_a(input logic [N-1:0] v, input logic [8*N-1:0] d, input int hold,
                         output logic [N-1:0] rdy, output logic [7:0] txv, output logic [1:0] gid,
                         output logic wr, output logic bsy_hold, output int extra_wr,
                         output int busy_rdy, output logic bsy_end);
    valid_a = v; data_a = d; done_a = 1'b0;
    #1 rdy = ready_a;
    tick();
    valid_a = '0; data_a = $urandom;
    txv = txv_a; gid = gid_a; wr = txw_a; bsy_hold = busy_a;
    extra_wr = 0; busy_rdy = 0;
    for (int i = 0; i < hold; i++) begin
      valid_a = N'($urandom);
      #1;
      if (ready_a !== '0) busy_rdy++;
      tick();
      if (txw_a !== 1'b0) extra_wr++;
      if (busy_a !== 1'b1) bsy_hold = 1'b0;
    end
    valid_a = '0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    bsy_end = busy_a;
    if (txw_a !== 1'b0) extra_wr++;
  endtask

  task automatic test_reset();
    srst_n = 1'b0; valid_a = '1; valid_b = '0; done_a = 1'b0; done_b = 1'b0;
    tick(); tick();
    n_tests++; if (ready_a !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", ready_a); end
    n_tests++; if (txv_a !== 8'h00) begin n_fail++; $display("FAIL reset_tx_value: got %h expected 00", txv_a); end
    n_tests++; if (txw_a !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", txw_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_tests++; if (gid_a !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", gid_a); end
    srst_n = 1'b1; valid_a = '0; m_ptr = N - 1;
    tick();
  endtask

  task automatic test_single();
    logic [N-1:0] rdy; logic [7:0] txv; logic [1:0] gid; logic wr, bh, be; int ew, br;
    serve_a(4'b0001, {8'h5C, 8'h3B, 8'h2A, 8'hA5}, 3, rdy, txv, gid, wr, bh, ew, br, be);
    n_tests++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", rdy); end
    n_tests++; if (txv !== 8'hA5) begin n_fail++; $display("FAIL single_tx_value: got %h expected a5", txv); end
    n_tests++; if (wr !== 1'b1) begin n_fail++; $display("FAIL single_write: got %b expected 1", wr); end
    n_tests++; if (bh !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold: got %b expected 1", bh); end
    n_tests++; if (ew != 0) begin n_fail++; $display("FAIL single_extra_write: got %0d expected 0", ew); end
    n_tests++; if (br != 0) begin n_fail++; $display("FAIL single_ready_while_busy: got %0d expected 0", br); end
    n_tests++; if (be !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", be); end
    m_ptr = 0;
  endtask

  task automatic test_contention();
    logic [N-1:0] rdy; logic [7:0] txv; logic [1:0] gid; logic wr, bh, be; int ew, br, exp;
    logic [8*N-1:0] d;
    do_reset();
    d = 32'h43322110;
    for (int n = 0; n < 5; n++) begin
      exp = model_pick(4'b1111, m_ptr);
      serve_a(4'b1111, d, 1, rdy, txv, gid, wr, bh, ew, br, be);
      n_tests++; if (rdy !== (N'(1) << exp)) begin n_fail++; $display("FAIL contention_ready[%0d]: got %b expected idx %0d", n, rdy, exp); end
      n_tests++; if (txv !== d[exp*8 +: 8]) begin n_fail++; $display("FAIL contention_byte[%0d]: got %h expected %h", n, txv, d[exp*8 +: 8]); end
      n_tests++; if (gid !== 2'(exp)) begin n_fail++; $display("FAIL contention_grant_id[%0d]: got %0d expected %0d", n, gid, exp); end
      m_ptr = exp;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, v; logic [7:0] txv; logic [1:0] gid; logic wr, bh, be; int ew, br, exp;
    logic [8*N-1:0] d;
    for (int n = 0; n < 40; n++) begin
      v = N'($urandom);
      d = $urandom;
      if (v == '0) begin
        valid_a = '0;
        #1;
        n_tests++; if (ready_a !== '0) begin n_fail++; $display("FAIL rand_idle_ready[%0d]: got %b expected 0000", n, ready_a); end
        tick();
        n_tests++; if (txw_a !== 1'b0) begin n_fail++; $display("FAIL rand_idle_write[%0d]: got %b expected 0", n, txw_a); end
      end else begin
        exp = model_pick(v, m_ptr);
        serve_a(v, d, $urandom_range(1, 4), rdy, txv, gid, wr, bh, ew, br, be);
        n_tests++; if (rdy !== (N'(1) << exp)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected idx %0d (valid %b)", n, rdy, exp, v); end
        n_tests++; if (txv !== d[exp*8 +: 8]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h expected %h", n, txv, d[exp*8 +: 8]); end
        n_tests++; if (gid !== 2'(exp)) begin n_fail++; $display("FAIL rand_grant_id[%0d]: got %0d expected %0d", n, gid, exp); end
        n_tests++; if (wr !== 1'b1 || ew != 0) begin n_fail++; $display("FAIL rand_write[%0d]: got strobe %b extra %0d expected 1 and 0", n, wr, ew); end
        n_tests++; if (bh !== 1'b1 || be !== 1'b0) begin n_fail++; $display("FAIL rand_busy[%0d]: got hold %b end %b expected 1 and 0", n, bh, be); end
        n_tests++; if (br != 0) begin n_fail++; $display("FAIL rand_ready_while_busy[%0d]: got %0d expected 0", n, br); end
        m_ptr = exp;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rdy; logic [7:0] txv; logic [1:0] gid; logic wr, bh, be; int ew, br, exp;
    // serve_a offers the next request in the first cycle after the done edge
    for (int n = 0; n < 3; n++) begin
      exp = model_pick(4'b0110, m_ptr);
      serve_a(4'b0110, 32'hD4C3B2A1, 1, rdy, txv, gid, wr, bh, ew, br, be);
      n_tests++; if (rdy !== (N'(1) << exp)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected idx %0d", n, rdy, exp); end
      m_ptr = exp;
    end
  endtask

  task automatic test_spurious_done();
    int exp;
    valid_a = '0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    n_tests++; if (busy_a !== 1'b0 || txw_a !== 1'b0) begin n_fail++; $display("FAIL idle_done: got busy %b write %b expected 0 0", busy_a, txw_a); end
    exp = model_pick(4'b1000, m_ptr);
    valid_a = 4'b1000; data_a = 32'h7E000000;
    tick();
    valid_a = '0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    n_tests++; if (busy_a !== 1'b1 || txw_a !== 1'b0) begin n_fail++; $display("FAIL write_cycle_done: got busy %b write %b expected 1 0", busy_a, txw_a); end
    tick(); tick();
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL write_cycle_done_hold: got busy %b expected 1", busy_a); end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    n_tests++; if (busy_a !== 1'b0 || txv_a !== 8'h7E) begin n_fail++; $display("FAIL spurious_end: got busy %b byte %h expected 0 7e", busy_a, txv_a); end
    m_ptr = exp;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] rdy; logic [7:0] txv; logic [1:0] gid; logic wr, bh, be; int ew, br;
    do_reset();
    valid_a = 4'b0100; data_a = 32'h00990000;
    tick();
    valid_a = '0;
    tick(); tick();
    n_tests++; if (busy_a !== 1'b1 || gid_a !== 2'd2) begin n_fail++; $display("FAIL midreset_setup: got busy %b grant %0d expected 1 2", busy_a, gid_a); end
    srst_n = 1'b0;
    tick();
    n_tests++; if (busy_a !== 1'b0 || txv_a !== 8'h00 || gid_a !== 2'd0 || txw_a !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got busy %b byte %h grant %0d write %b expected 0 00 0 0", busy_a, txv_a, gid_a, txw_a); end
    srst_n = 1'b1; m_ptr = N - 1;
    serve_a(4'b1111, 32'h44332211, 1, rdy, txv, gid, wr, bh, ew, br, be);
    n_tests++; if (rdy !== 4'b0001 || txv !== 8'h11) begin n_fail++; $display("FAIL midreset_first_grant: got %b byte %h expected 0001 11", rdy, txv); end
    m_ptr = 0;
  endtask

  task automatic test_gap();
    int idle; logic bad;
    do_reset();
    valid_b = 4'b0011; data_b = 32'h0000BBAA;
    #1;
    n_tests++; if (ready_b !== 4'b0001) begin n_fail++; $display("FAIL gap_first_ready: got %b expected 0001", ready_b); end
    tick(); tick(); tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    idle = 0; bad = 1'b0;
    while (ready_b === '0 && idle < 20) begin
      if (busy_b !== 1'b0 || txw_b !== 1'b0) bad = 1'b1;
      tick();
      idle++;
    end
    n_tests++; if (idle != GAP_B) begin n_fail++; $display("FAIL gap_length: got %0d idle cycles expected %0d", idle, GAP_B); end
    n_tests++; if (ready_b !== 4'b0010) begin n_fail++; $display("FAIL gap_next_ready: got %b expected 0010", ready_b); end
    n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL gap_quiet: got activity %b expected 0", bad); end
    tick();
    n_tests++; if (txv_b !== 8'hBB || gid_b !== 2'd1) begin n_fail++; $display("FAIL gap_second_byte: got %h grant %0d expected bb 1", txv_b, gid_b); end
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    n_tests++; if (locked_b !== 1'b0) begin n_fail++; $display("FAIL gap_locked: got %b expected 0", locked_b); end
`endif
    valid_b = '0;
  endtask

`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] rdy; logic [7:0] txv; logic [1:0] gid; logic wr, bh, be; int ew, br;
    logic [N-1:0] seq_v [5] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0101};
    logic [N-1:0] seq_l [5] = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b1111};
    logic [N-1:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic         exp_k [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      last_a = seq_l[n];
      serve_a(seq_v[n], 32'h44332211, 1, rdy, txv, gid, wr, bh, ew, br, be);
      n_tests++; if (rdy !== exp_r[n]) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b expected %b", n, rdy, exp_r[n]); end
      n_tests++; if (locked_a !== exp_k[n]) begin n_fail++; $display("FAIL lock_flag[%0d]: got %b expected %b", n, locked_a, exp_k[n]); end
      if (n == 1) begin
        valid_a = 4'b0001;
        #1;
        n_tests++; if (ready_a !== '0) begin n_fail++; $display("FAIL lock_excludes_other: got %b expected 0000", ready_a); end
        valid_a = '0;
      end
    end
    last_a = '1;
    m_ptr = 2;
  endtask
`endif

  initial begin
    srst_n = 1'b0; valid_a = '0; valid_b = '0; data_a = '0; data_b = '0;
    done_a = 1'b0; done_b = 1'b0;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    last_a = '1;
`endif
    test_reset();
    test_single();
    test_contention();
    test_random();
    test_back_to_back();
    test_spurious_done();
    test_reset_mid();
    test_gap();
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
